// File: rtl/bug_spawner.sv
// Bug spawner: sequences one on-screen bug through delay, spawn, move and
// squash phases, driven by the per-frame tick. All outputs are registered.
//
// state  | meaning
// IDLE   | game stopped, nothing drawn
// DELAY  | counting frame ticks before the next bug appears
// SPAWN  | one cycle: latch random y, reset x, request next random value
// MOVE   | bug drawn and walking right one STEP per frame tick
// SQUASH | bug drawn in squashed pose for a fixed number of frame ticks
module bug_spawner #(
  parameter int SCREEN_W      = 640,
  parameter int STEP          = 1,
  parameter int DELAY_FRAMES  = 30,
  parameter int SQUASH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [14:0] rand_in,
  input  logic        hit,
  output logic        advance,
  output logic [14:0] bug_x,
  output logic [14:0] bug_y,
  output logic        bug_visible,
  output logic        squashed,
  output logic        score_pulse,
  output logic        escape_pulse
);

  // A zero frame count behaves as one tick.
  localparam int DLY_EFF = (DELAY_FRAMES  < 1) ? 1 : DELAY_FRAMES;
  localparam int SQ_EFF  = (SQUASH_FRAMES < 1) ? 1 : SQUASH_FRAMES;
  localparam int DW      = $clog2(DLY_EFF + 1);
  localparam int SW      = $clog2(SQ_EFF + 1);

  localparam logic [DW-1:0] DLY_LOAD = DW'(DLY_EFF);
  localparam logic [SW-1:0] SQ_LOAD  = SW'(SQ_EFF);
  localparam logic [DW-1:0] DLY_ONE  = DW'(1);
  localparam logic [SW-1:0] SQ_ONE   = SW'(1);
  localparam logic [14:0]   STEP_V   = 15'(STEP);
  localparam logic [14:0]   SCREEN_V = 15'(SCREEN_W);

  typedef enum logic [2:0] {IDLE, DELAY, SPAWN, MOVE, SQUASH} state_t;

  state_t        state, state_n;
  logic [DW-1:0] delay_cnt, delay_n;
  logic [SW-1:0] squash_cnt, squash_n;
  logic [14:0]   x_n, y_n, x_adv;
  logic          vis_n, sq_n, adv_n, score_n, esc_n;

  assign x_adv = bug_x + STEP_V;

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      squash_cnt   <= '0;
      bug_x        <= '0;
      bug_y        <= '0;
      bug_visible  <= 1'b0;
      squashed     <= 1'b0;
      advance      <= 1'b0;
      score_pulse  <= 1'b0;
      escape_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      delay_cnt    <= delay_n;
      squash_cnt   <= squash_n;
      bug_x        <= x_n;
      bug_y        <= y_n;
      bug_visible  <= vis_n;
      squashed     <= sq_n;
      advance      <= adv_n;
      score_pulse  <= score_n;
      escape_pulse <= esc_n;
    end
  end

  // Next state and next output values; pulses default low every cycle.
  always_comb begin
    state_n  = state;
    delay_n  = delay_cnt;
    squash_n = squash_cnt;
    x_n      = bug_x;
    y_n      = bug_y;
    vis_n    = bug_visible;
    sq_n     = squashed;
    adv_n    = 1'b0;
    score_n  = 1'b0;
    esc_n    = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      vis_n   = 1'b0;
      sq_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = DELAY;
          delay_n = DLY_LOAD;
          vis_n   = 1'b0;
          sq_n    = 1'b0;
        end
        DELAY: begin
          if (frame_tick) begin
            if (delay_cnt <= DLY_ONE) begin
              delay_n = '0;
              state_n = SPAWN;
              // advance is registered, so raising it here makes it
              // coincide exactly with the SPAWN cycle.
              adv_n   = 1'b1;
            end else begin
              delay_n = delay_cnt - DLY_ONE;
            end
          end
        end
        SPAWN: begin
          y_n     = rand_in;
          x_n     = '0;
          vis_n   = 1'b1;
          state_n = MOVE;
        end
        MOVE: begin
          if (hit) begin
            score_n  = 1'b1;
            sq_n     = 1'b1;
            squash_n = SQ_LOAD;
            state_n  = SQUASH;
          end else if (frame_tick) begin
            if (x_adv >= SCREEN_V) begin
              esc_n   = 1'b1;
              vis_n   = 1'b0;
              delay_n = DLY_LOAD;
              state_n = DELAY;
            end else begin
              x_n = x_adv;
            end
          end
        end
        SQUASH: begin
          if (frame_tick) begin
            if (squash_cnt <= SQ_ONE) begin
              squash_n = '0;
              sq_n     = 1'b0;
              vis_n    = 1'b0;
              delay_n  = DLY_LOAD;
              state_n  = DELAY;
            end else begin
              squash_n = squash_cnt - SQ_ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bug_spawner.sv
// Directed bench for bug_spawner with a small screen and short frame counts.
module tb_bug_spawner;

  logic        clk = 1'b0;
  logic        rst, enable, frame_tick, hit;
  logic [14:0] rand_in;
  logic        advance, bug_visible, squashed, score_pulse, escape_pulse;
  logic [14:0] bug_x, bug_y;

  int total = 0;
  int bad   = 0;
  int adv_cnt = 0, score_cnt = 0, esc_cnt = 0;

  bug_spawner #(
    .SCREEN_W(8), .STEP(2), .DELAY_FRAMES(2), .SQUASH_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .rand_in(rand_in), .hit(hit), .advance(advance), .bug_x(bug_x),
    .bug_y(bug_y), .bug_visible(bug_visible), .squashed(squashed),
    .score_pulse(score_pulse), .escape_pulse(escape_pulse)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (advance === 1'b1)      adv_cnt++;
    if (score_pulse === 1'b1)  score_cnt++;
    if (escape_pulse === 1'b1) esc_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each tick is one high cycle followed by one idle cycle.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; hit = 1'b1; frame_tick = 1'b1; rand_in = 15'd200;
    cyc(); cyc();
    total++;
    if ({advance, bug_x, bug_y, bug_visible, squashed, score_pulse, escape_pulse} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d vis=%b sq=%b adv=%b sc=%b esc=%b, want all 0",
               bug_x, bug_y, bug_visible, squashed, advance, score_pulse, escape_pulse);
    end
    rst = 1'b0; enable = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    cyc();
  endtask

  task automatic test_spawn();
    int a0, s0;
    a0 = adv_cnt; s0 = score_cnt;
    enable = 1'b1; rand_in = 15'd200;
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    tick_n(1);
    total++;
    if (bug_visible !== 1'b0 || adv_cnt - a0 != 0) begin
      bad++;
      $display("FAIL spawn_early: got vis=%b adv=%0d, want vis=0 adv=0", bug_visible, adv_cnt - a0);
    end
    tick_n(1);
    total++;
    if (adv_cnt - a0 != 1) begin
      bad++;
      $display("FAIL spawn_advance: got %0d pulses, want 1", adv_cnt - a0);
    end
    total++;
    if (bug_y !== 15'd200 || bug_x !== 15'd0 || bug_visible !== 1'b1 || squashed !== 1'b0) begin
      bad++;
      $display("FAIL spawn_pos: got x=%0d y=%0d vis=%b sq=%b, want x=0 y=200 vis=1 sq=0",
               bug_x, bug_y, bug_visible, squashed);
    end
    total++;
    if (score_cnt - s0 != 0) begin
      bad++;
      $display("FAIL hit_in_delay: got %0d score pulses, want 0", score_cnt - s0);
    end
    rand_in = 15'd128;
    cyc();
    total++;
    if (bug_y !== 15'd200 || advance !== 1'b0) begin
      bad++;
      $display("FAIL y_hold: got y=%0d adv=%b, want y=200 adv=0", bug_y, advance);
    end
  endtask

  task automatic test_escape();
    int e0;
    logic [14:0] exp_x;
    e0 = esc_cnt;
    for (int i = 1; i <= 3; i++) begin
      tick_n(1);
      exp_x = 15'(2 * i);
      total++;
      if (bug_x !== exp_x || bug_visible !== 1'b1) begin
        bad++;
        $display("FAIL move_step%0d: got x=%0d vis=%b, want x=%0d vis=1", i, bug_x, bug_visible, exp_x);
      end
    end
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    total++;
    if (escape_pulse !== 1'b1 || bug_visible !== 1'b0 || bug_x !== 15'd6) begin
      bad++;
      $display("FAIL escape: got esc=%b vis=%b x=%0d, want esc=1 vis=0 x=6", escape_pulse, bug_visible, bug_x);
    end
    cyc();
    total++;
    if (escape_pulse !== 1'b0 || esc_cnt - e0 != 1) begin
      bad++;
      $display("FAIL escape_once: got esc=%b count=%0d, want esc=0 count=1", escape_pulse, esc_cnt - e0);
    end
  endtask

  task automatic test_squash();
    int s0;
    s0 = score_cnt;
    tick_n(2);
    total++;
    if (bug_y !== 15'd128 || bug_visible !== 1'b1 || bug_x !== 15'd0) begin
      bad++;
      $display("FAIL respawn: got x=%0d y=%0d vis=%b, want x=0 y=128 vis=1", bug_x, bug_y, bug_visible);
    end
    tick_n(2);
    hit = 1'b1;
    cyc();
    total++;
    if (score_pulse !== 1'b1 || squashed !== 1'b1 || bug_visible !== 1'b1 || bug_x !== 15'd4) begin
      bad++;
      $display("FAIL squash_start: got sc=%b sq=%b vis=%b x=%0d, want sc=1 sq=1 vis=1 x=4",
               score_pulse, squashed, bug_visible, bug_x);
    end
    tick_n(2);
    total++;
    if (squashed !== 1'b1 || bug_visible !== 1'b1 || bug_x !== 15'd4 || bug_y !== 15'd128) begin
      bad++;
      $display("FAIL squash_hold: got sq=%b vis=%b x=%0d y=%0d, want sq=1 vis=1 x=4 y=128",
               squashed, bug_visible, bug_x, bug_y);
    end
    tick_n(1);
    total++;
    if (squashed !== 1'b0 || bug_visible !== 1'b0 || bug_x !== 15'd4) begin
      bad++;
      $display("FAIL squash_end: got sq=%b vis=%b x=%0d, want sq=0 vis=0 x=4", squashed, bug_visible, bug_x);
    end
    total++;
    if (score_cnt - s0 != 1) begin
      bad++;
      $display("FAIL squash_single_score: got %0d pulses, want 1", score_cnt - s0);
    end
    hit = 1'b0;
  endtask

  task automatic test_simultaneous();
    int e0;
    rand_in = 15'd252;
    tick_n(2);
    tick_n(3);
    total++;
    if (bug_x !== 15'd6 || bug_y !== 15'd252) begin
      bad++;
      $display("FAIL simul_setup: got x=%0d y=%0d, want x=6 y=252", bug_x, bug_y);
    end
    e0 = esc_cnt;
    hit = 1'b1; frame_tick = 1'b1;
    cyc();
    hit = 1'b0; frame_tick = 1'b0;
    total++;
    if (score_pulse !== 1'b1 || escape_pulse !== 1'b0 || bug_x !== 15'd6 || squashed !== 1'b1) begin
      bad++;
      $display("FAIL simul_hit_wins: got sc=%b esc=%b x=%0d sq=%b, want sc=1 esc=0 x=6 sq=1",
               score_pulse, escape_pulse, bug_x, squashed);
    end
    cyc();
    total++;
    if (esc_cnt - e0 != 0) begin
      bad++;
      $display("FAIL simul_no_escape: got %0d escape pulses, want 0", esc_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_squash();
    int a0;
    rst = 1'b1;
    cyc();
    total++;
    if ({advance, bug_x, bug_y, bug_visible, squashed, score_pulse, escape_pulse} !== 36'd0) begin
      bad++;
      $display("FAIL reset_squash: got x=%0d y=%0d vis=%b sq=%b adv=%b sc=%b esc=%b, want all 0",
               bug_x, bug_y, bug_visible, squashed, advance, score_pulse, escape_pulse);
    end
    rst = 1'b0;
    a0 = adv_cnt;
    cyc();
    tick_n(1);
    total++;
    if (bug_visible !== 1'b0 || adv_cnt - a0 != 0) begin
      bad++;
      $display("FAIL reset_respawn_early: got vis=%b adv=%0d, want vis=0 adv=0", bug_visible, adv_cnt - a0);
    end
    tick_n(1);
    total++;
    if (adv_cnt - a0 != 1 || bug_visible !== 1'b1 || bug_x !== 15'd0 || bug_y !== 15'd252) begin
      bad++;
      $display("FAIL reset_respawn: got adv=%0d vis=%b x=%0d y=%0d, want adv=1 vis=1 x=0 y=252",
               adv_cnt - a0, bug_visible, bug_x, bug_y);
    end
  endtask

  task automatic test_enable_drop();
    int a0, s0, e0;
    tick_n(1);
    a0 = adv_cnt; s0 = score_cnt; e0 = esc_cnt;
    enable = 1'b0; hit = 1'b1;
    cyc();
    hit = 1'b0;
    total++;
    if (bug_visible !== 1'b0 || squashed !== 1'b0 || bug_x !== 15'd2 || bug_y !== 15'd252) begin
      bad++;
      $display("FAIL disable: got vis=%b sq=%b x=%0d y=%0d, want vis=0 sq=0 x=2 y=252",
               bug_visible, squashed, bug_x, bug_y);
    end
    tick_n(2);
    total++;
    if (bug_visible !== 1'b0 || adv_cnt != a0 || score_cnt != s0 || esc_cnt != e0) begin
      bad++;
      $display("FAIL disable_quiet: got vis=%b adv=%0d sc=%0d esc=%0d, want vis=0 and no pulses",
               bug_visible, adv_cnt - a0, score_cnt - s0, esc_cnt - e0);
    end
    enable = 1'b1;
    cyc();
    tick_n(1);
    total++;
    if (bug_visible !== 1'b0 || adv_cnt != a0) begin
      bad++;
      $display("FAIL reenable_delay: got vis=%b adv=%0d, want vis=0 adv=0", bug_visible, adv_cnt - a0);
    end
    tick_n(1);
    total++;
    if (adv_cnt - a0 != 1 || bug_visible !== 1'b1 || bug_x !== 15'd0) begin
      bad++;
      $display("FAIL reenable_spawn: got adv=%0d vis=%b x=%0d, want adv=1 vis=1 x=0",
               adv_cnt - a0, bug_visible, bug_x);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; hit = 1'b0; rand_in = 15'd0;
    test_reset();
    test_spawn();
    test_escape();
    test_squash();
    test_simultaneous();
    test_reset_mid_squash();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
